// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
// The slave modport is the arbiter's view; master is the requesters and memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between instruction
// fetch and load/store; every output is registered from the next-state logic.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64
) (
    input  logic              clk,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        SEL_IF = 1'b0,
        SEL_D  = 1'b1
    } sel_e;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    sel_e              sel_q, sel_d;
    sel_e              last_q, last_d;
    sel_e              win_s;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              capture_s;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    // On a tie the requester that was not granted last time wins.
    function automatic sel_e pick(input logic req_if, input logic req_d, input sel_e last);
        sel_e res;
        if (req_if && req_d) begin
            res = (last == SEL_D) ? SEL_IF : SEL_D;
        end else if (req_d) begin
            res = SEL_D;
        end else begin
            res = SEL_IF;
        end
        return res;
    endfunction

    // Next-state, arbitration and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        capture_s = 1'b0;
        win_s     = pick(bus.if_req, bus.d_req, last_q);

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ST_ISSUE;
                    sel_d   = win_s;
                    last_d  = win_s;
                    if (win_s == SEL_D) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        we_d    = bus.d_we;
                    end else begin
                        addr_d  = bus.if_addr;
                        wdata_d = {DATA_W{1'b0}};
                        we_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    capture_s = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_en_d   = (state_d == ST_ISSUE);
        mem_we_d   = (state_d == ST_ISSUE) && we_d;
        if_gnt_d   = (state_d == ST_ISSUE) && (sel_d == SEL_IF);
        d_gnt_d    = (state_d == ST_ISSUE) && (sel_d == SEL_D);
        if_valid_d = (state_d == ST_RESP) && (sel_d == SEL_IF);
        d_valid_d  = (state_d == ST_RESP) && (sel_d == SEL_D);
        busy_d     = (state_d != ST_IDLE);

        // Stores complete without touching d_rdata; the idle requester's data is never touched.
        if (capture_s && (sel_q == SEL_IF)) begin
            if_rdata_d = bus.mem_rdata[31:0];
            d_rdata_d  = d_rdata_q;
        end else if (capture_s && (sel_q == SEL_D) && !we_q) begin
            if_rdata_d = if_rdata_q;
            d_rdata_d  = bus.mem_rdata;
        end else begin
            if_rdata_d = if_rdata_q;
            d_rdata_d  = d_rdata_q;
        end
    end

    // State, latched request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_IF;
            last_q     <= SEL_D;
            cnt_q      <= 4'd0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            we_q       <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
